// File: rtl/render_pkg.sv
// Shared mode codes, FSM state encoding and helpers for the render scan pipeline.
package render_pkg;

   localparam logic [1:0] ModeMove   = 2'b10;
   localparam logic [1:0] ModeRotate = 2'b11;

   typedef logic [2:0] state_t;

   localparam state_t StIdle  = 3'd0;
   localparam state_t StInit  = 3'd1;
   localparam state_t StScan  = 3'd2;
   localparam state_t StDrain = 3'd3;
   localparam state_t StDone  = 3'd4;

   function automatic logic mode_valid(input logic [1:0] mode);
      return (mode == ModeMove) || (mode == ModeRotate);
   endfunction

endpackage

// File: rtl/render_pipe_stage.sv
// One coordinate/valid slot of the render shift chain; loads only on a common advance.
module render_pipe_stage #(
   parameter int unsigned COORD_W = 10
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               advance,
   input  logic               in_valid,
   input  logic [COORD_W-1:0] in_x,
   input  logic [COORD_W-1:0] in_y,
   output logic               out_valid,
   output logic [COORD_W-1:0] out_x,
   output logic [COORD_W-1:0] out_y
);

   logic               valid_q;
   logic [COORD_W-1:0] x_q;
   logic [COORD_W-1:0] y_q;

   // Invalid slots carry zero coordinates so downstream never sees stale pixels.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
      end else if (advance) begin
         valid_q <= in_valid;
         x_q     <= in_valid ? in_x : '0;
         y_q     <= in_valid ? in_y : '0;
      end
   end

   assign out_valid = valid_q;
   assign out_x     = x_q;
   assign out_y     = y_q;

endmodule

// File: rtl/render_scan_pipe.sv
// Raster scan generator feeding a stallable coordinate pipeline; counts completed frames.
module render_scan_pipe
   import render_pkg::*;
#(
   parameter int unsigned H_PIXELS   = 800,
   parameter int unsigned V_PIXELS   = 600,
   parameter int unsigned COORD_W    = 10,
   parameter int unsigned PIPE_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  draw_req,
   input  logic [1:0]            draw_mode,
   input  logic                  tail_ready,
   output logic [PIPE_DEPTH-1:0] stage_valid,
   output logic [COORD_W-1:0]    issue_x,
   output logic [COORD_W-1:0]    issue_y,
   output logic [COORD_W-1:0]    tail_x,
   output logic [COORD_W-1:0]    tail_y,
   output logic                  tail_valid,
   output logic                  busy,
   output logic                  frame_done,
   output logic [1:0]            frame_mode,
   output logic [15:0]           frame_cnt
);

   localparam int unsigned MaxDim = (H_PIXELS > V_PIXELS) ? H_PIXELS : V_PIXELS;
   localparam logic [COORD_W-1:0] XLast = COORD_W'(H_PIXELS - 1);
   localparam logic [COORD_W-1:0] YLast = COORD_W'(V_PIXELS - 1);

   if (PIPE_DEPTH < 2 || (64'd1 << COORD_W) <= 64'(MaxDim)) begin : g_bad_params
      $error("render_scan_pipe: COORD_W too narrow or PIPE_DEPTH below 2");
   end

   state_t             state_q, state_d;
   logic [COORD_W-1:0] cnt_x_q, cnt_x_d;
   logic [COORD_W-1:0] cnt_y_q, cnt_y_d;
   logic               pend_q, pend_d;
   logic [1:0]         pend_mode_q, pend_mode_d;
   logic [1:0]         frame_mode_q, frame_mode_d;
   logic [15:0]        frame_cnt_q, frame_cnt_d;
   logic               issue_v;
   logic               req_ok;
   logic               head_last;
   logic               tail_last;

   logic [COORD_W-1:0] x_chain [PIPE_DEPTH];
   logic [COORD_W-1:0] y_chain [PIPE_DEPTH];

   for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
      logic               in_v;
      logic [COORD_W-1:0] in_x;
      logic [COORD_W-1:0] in_y;
      if (k == 0) begin : g_head
         assign in_v = issue_v;
         assign in_x = cnt_x_q;
         assign in_y = cnt_y_q;
      end else begin : g_body
         assign in_v = stage_valid[k-1];
         assign in_x = x_chain[k-1];
         assign in_y = y_chain[k-1];
      end
      render_pipe_stage #(.COORD_W(COORD_W)) u_stage (
         .clk       (clk),
         .reset_n   (reset_n),
         .advance   (tail_ready),
         .in_valid  (in_v),
         .in_x      (in_x),
         .in_y      (in_y),
         .out_valid (stage_valid[k]),
         .out_x     (x_chain[k]),
         .out_y     (y_chain[k])
      );
   end

   assign issue_x    = x_chain[0];
   assign issue_y    = y_chain[0];
   assign tail_x     = x_chain[PIPE_DEPTH-1];
   assign tail_y     = y_chain[PIPE_DEPTH-1];
   assign tail_valid = stage_valid[PIPE_DEPTH-1];
   assign busy       = (state_q != StIdle);
   assign frame_done = (state_q == StDone) && tail_ready;
   assign frame_mode = frame_mode_q;
   assign frame_cnt  = frame_cnt_q;

   assign req_ok    = draw_req && mode_valid(draw_mode);
   assign head_last = stage_valid[0] && (issue_x == XLast) && (issue_y == YLast);
   assign tail_last = tail_valid && (tail_x == XLast) && (tail_y == YLast);

   always_comb begin
      state_d      = state_q;
      cnt_x_d      = cnt_x_q;
      cnt_y_d      = cnt_y_q;
      pend_d       = pend_q;
      pend_mode_d  = pend_mode_q;
      frame_mode_d = frame_mode_q;
      frame_cnt_d  = frame_cnt_q;
      issue_v      = 1'b0;

      // Request capture keeps running even while the pipe is stalled.
      if (busy && req_ok) begin
         pend_d      = 1'b1;
         pend_mode_d = draw_mode;
      end

      if (tail_ready) begin
         unique case (state_q)
            StIdle: begin
               if (req_ok) begin
                  state_d      = StInit;
                  frame_mode_d = draw_mode;
               end
            end
            StInit: begin
               issue_v = 1'b1;
               state_d = StScan;
            end
            StScan: begin
               if (head_last) state_d = StDrain;
               else           issue_v = 1'b1;
            end
            StDrain: begin
               if (tail_last) state_d = StDone;
            end
            StDone: begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               if (req_ok || pend_q) begin
                  state_d      = StInit;
                  frame_mode_d = req_ok ? draw_mode : pend_mode_q;
                  pend_d       = 1'b0;
               end else begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end

      // Counters hold the next pixel to issue; they sit at (0,0) outside a scan.
      if (issue_v) begin
         if (cnt_x_q == XLast) begin
            cnt_x_d = '0;
            cnt_y_d = cnt_y_q + 1'b1;
         end else begin
            cnt_x_d = cnt_x_q + 1'b1;
         end
      end else if (state_q != StInit && state_q != StScan) begin
         cnt_x_d = '0;
         cnt_y_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         cnt_x_q      <= '0;
         cnt_y_q      <= '0;
         pend_q       <= 1'b0;
         pend_mode_q  <= 2'b00;
         frame_mode_q <= 2'b00;
         frame_cnt_q  <= 16'd0;
      end else begin
         state_q      <= state_d;
         cnt_x_q      <= cnt_x_d;
         cnt_y_q      <= cnt_y_d;
         pend_q       <= pend_d;
         pend_mode_q  <= pend_mode_d;
         frame_mode_q <= frame_mode_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

endmodule

// File: doc/render_scan_pipe.md
RENDER_SCAN_PIPE -- requirements
Module: render_scan_pipe

Interface
REQ-001 The block SHALL have parameter H_PIXELS, default 800: pixels per line.
REQ-002 The block SHALL have parameter V_PIXELS, default 600: lines per frame.
REQ-003 The block SHALL have parameter COORD_W, default 10: coordinate width in bits.
REQ-004 The block SHALL have parameter PIPE_DEPTH, default 4, minimum 2: number of pipeline stages, stage 0 = issue, stage PIPE_DEPTH-1 = tail.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port draw_req, input, 1 bit: render request, sampled every cycle.
REQ-008 The block SHALL have port draw_mode, input, 2 bits: MOVE=2'b10 or ROTATE=2'b11, with all other codes invalid.
REQ-009 The block SHALL have port tail_ready, input, 1 bit: downstream accept; when low the whole pipeline stalls.
REQ-010 The block SHALL have port stage_valid, output, PIPE_DEPTH bits: per-stage valid flags.
REQ-011 The block SHALL have ports issue_x and issue_y, outputs, COORD_W bits each: stage-0 coordinates.
REQ-012 The block SHALL have ports tail_x and tail_y, outputs, COORD_W bits each: tail-stage coordinates.
REQ-013 The block SHALL have port tail_valid, output, 1 bit, equal to stage_valid[PIPE_DEPTH-1].
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse per completed frame.
REQ-016 The block SHALL have port frame_mode, output, 2 bits: mode latched for the current or last frame.
REQ-017 The block SHALL have port frame_cnt, output, 16 bits: count of completed frames.

Function
REQ-018 The FSM SHALL have states IDLE, INIT, SCAN, DRAIN and DONE.
REQ-019 In IDLE, draw_req=1 with a valid draw_mode SHALL move the FSM to INIT next cycle and latch frame_mode; an invalid mode SHALL be ignored.
REQ-020 INIT SHALL last exactly 1 cycle, clear the raster counters to (0,0) and go to SCAN.
REQ-021 Each advancing SCAN cycle SHALL issue one pixel into stage 0 in raster order: x increments, and at x=H_PIXELS-1 x wraps to 0 and y increments.
REQ-022 After issuing (H_PIXELS-1, V_PIXELS-1), the FSM SHALL enter DRAIN with no further issues.
REQ-023 Stage k SHALL hold the pixel issued k advancing cycles earlier, giving a latency of PIPE_DEPTH-1 advancing cycles from issue to tail.
REQ-024 An advancing cycle SHALL be a cycle with tail_ready=1.
REQ-025 When tail_ready=0, all stage registers, valids, raster counters and the FSM SHALL hold, except that request capture (REQ-028) continues.
REQ-026 DRAIN SHALL exit to DONE on the advancing cycle in which the tail holds (H_PIXELS-1, V_PIXELS-1) with tail_valid=1.
REQ-027 DONE SHALL last 1 cycle, assert frame_done, and increment frame_cnt modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-028 A valid draw_req arriving while busy=1, including in the DONE cycle, SHALL set a one-deep pending flag and store its mode, with the latest request overwriting the stored mode.
REQ-029 From DONE, the FSM SHALL go to INIT if a request is pending, loading frame_mode from the pending mode and clearing the flag; otherwise it SHALL go to IDLE.
REQ-030 Coordinates of invalid stages SHALL be don't-care, but the implementation SHALL drive them as zero.
REQ-031 The block SHALL fail elaboration if 2^COORD_W <= max(H_PIXELS, V_PIXELS) or if PIPE_DEPTH < 2.

Reset
REQ-032 While reset_n=0, the block SHALL be in state IDLE with all stage_valid=0, all coordinates=0, busy=0, frame_done=0, frame_mode=2'b00, frame_cnt=0 and pending cleared.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately, without asserting frame_done and without incrementing frame_cnt.
REQ-034 After reset_n deasserts, the block SHALL act only on a new draw_req.

Structure
REQ-035 The MOVE/ROTATE codes and the FSM state encoding SHALL live in the shared package render_pkg.
REQ-036 The coordinate/valid shift chain SHALL be a separate sub-module, render_pipe_stage, with one instance per stage and a common advance enable.

Verification
REQ-037 With H=4, V=3, PIPE_DEPTH=4, tail_ready=1 and draw_req=1 with MOVE in cycle 0: INIT SHALL occur in cycle 1, SCAN in cycles 2-13, DRAIN in cycles 14-16, frame_done=1 in cycle 17, busy=0 in cycle 18, and frame_cnt SHALL be 1.
REQ-038 With the same setup and tail_ready=0 for 5 cycles mid-SCAN, frame_done SHALL arrive in cycle 22, and the tail sequence SHALL show the 12 raster pixels exactly once each, in order.
REQ-039 A ROTATE request in cycle 5 of a MOVE frame SHALL cause a second frame to start with INIT in cycle 18 and frame_mode=2'b11, with frame_cnt reaching 2.
REQ-040 draw_req with draw_mode=2'b01 in IDLE SHALL leave busy=0 and all outputs unchanged.
REQ-041 Asserting reset_n=0 in cycle 8 SHALL give all outputs their reset values in that same cycle, with no frame_done and frame_cnt=0.
REQ-042 With frame_cnt preloaded near 0xFFFF by running repeated frames, the next completed frame SHALL wrap frame_cnt to 0x0000.
